// File: rtl/cc_line_fill_deserializer.sv
// rtl/cc_line_fill_deserializer.sv - collects a wrapped critical-word-first read burst into one cache line
module cc_line_fill_deserializer #(
    parameter int DATA_W  = 64,
    parameter int BEATS   = 8,
    parameter int INDEX_W = 9,
    parameter int OFFS_W  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_valid_i,
    output logic                      miss_ready_o,
    input  logic [INDEX_W-1:0]        miss_index_i,
    input  logic [OFFS_W-1:0]         miss_offset_i,
    input  logic                      beat_valid_i,
    output logic                      beat_ready_o,
    input  logic [DATA_W-1:0]         beat_data_i,
    input  logic                      beat_last_i,
    output logic                      line_valid_o,
    input  logic                      line_ready_i,
    output logic [INDEX_W-1:0]        line_index_o,
    output logic [DATA_W*BEATS-1:0]   line_data_o,
    output logic                      err_o
);

    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int WORD_W  = OFFS_W - BYTE_SH;
    localparam int LINE_W  = DATA_W * BEATS;
    localparam logic [WORD_W-1:0] LAST_K = WORD_W'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_OUTPUT
    } state_t;

    state_t              state_q;
    logic                miss_ready_q;
    logic                beat_ready_q;
    logic                line_valid_q;
    logic                err_q;
    logic [INDEX_W-1:0]  index_q;
    logic [WORD_W-1:0]   w0_q;
    logic [WORD_W-1:0]   cnt_q;
    logic [LINE_W-1:0]   line_q;

    logic [WORD_W-1:0]   wr_word_d;
    logic                beat_hs_d;
    logic                at_last_k_d;

    // Word slot wraps naturally: WORD_W-bit add drops the carry.
    always_comb begin
        wr_word_d   = w0_q + cnt_q;
        beat_hs_d   = beat_valid_i && beat_ready_q;
        at_last_k_d = (cnt_q == LAST_K);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            miss_ready_q <= 1'b1;
            beat_ready_q <= 1'b0;
            line_valid_q <= 1'b0;
            err_q        <= 1'b0;
            index_q      <= '0;
            w0_q         <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_valid_i && miss_ready_q) begin
                        index_q      <= miss_index_i;
                        w0_q         <= miss_offset_i[OFFS_W-1:BYTE_SH];
                        cnt_q        <= '0;
                        line_q       <= '0;
                        miss_ready_q <= 1'b0;
                        beat_ready_q <= 1'b1;
                        state_q      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (beat_hs_d) begin
                        for (int w = 0; w < BEATS; w++) begin
                            if (wr_word_d == WORD_W'(w)) begin
                                line_q[w*DATA_W +: DATA_W] <= beat_data_i;
                            end
                        end
                        cnt_q <= cnt_q + 1'b1;
                        // Either an early rlast or a missing rlast ends the burst here.
                        if (beat_last_i || at_last_k_d) begin
                            if (beat_last_i != at_last_k_d) begin
                                err_q <= 1'b1;
                            end
                            beat_ready_q <= 1'b0;
                            line_valid_q <= 1'b1;
                            state_q      <= S_OUTPUT;
                        end
                    end
                end
                S_OUTPUT: begin
                    if (line_ready_i) begin
                        line_valid_q <= 1'b0;
                        miss_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    miss_ready_q <= 1'b1;
                    beat_ready_q <= 1'b0;
                    line_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign miss_ready_o = miss_ready_q;
    assign beat_ready_o = beat_ready_q;
    assign line_valid_o = line_valid_q;
    assign line_index_o = index_q;
    assign line_data_o  = line_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_cc_line_fill_deserializer.sv
// tb/tb_cc_line_fill_deserializer.sv - directed self-checking bench for cc_line_fill_deserializer
module tb_cc_line_fill_deserializer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         miss_valid_i = 1'b0;
    logic         miss_ready_o;
    logic [8:0]   miss_index_i = '0;
    logic [5:0]   miss_offset_i = '0;
    logic         beat_valid_i = 1'b0;
    logic         beat_ready_o;
    logic [63:0]  beat_data_i = '0;
    logic         beat_last_i = 1'b0;
    logic         line_valid_o;
    logic         line_ready_i = 1'b0;
    logic [8:0]   line_index_o;
    logic [511:0] line_data_o;
    logic         err_o;

    int n_checks = 0;
    int n_fail   = 0;

    cc_line_fill_deserializer dut (
        .clk          (clk),
        .rst          (rst),
        .miss_valid_i (miss_valid_i),
        .miss_ready_o (miss_ready_o),
        .miss_index_i (miss_index_i),
        .miss_offset_i(miss_offset_i),
        .beat_valid_i (beat_valid_i),
        .beat_ready_o (beat_ready_o),
        .beat_data_i  (beat_data_i),
        .beat_last_i  (beat_last_i),
        .line_valid_o (line_valid_o),
        .line_ready_i (line_ready_i),
        .line_index_o (line_index_o),
        .line_data_o  (line_data_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bv(input logic [7:0] b);
        return {b, 48'h5A5A_0000_A5A5, b};
    endfunction

    function automatic logic [511:0] ln(input logic [63:0] w0, w1, w2, w3, w4, w5, w6, w7);
        return {w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    // Waits for the handshake edge of the currently offered miss (is_miss=1) or beat.
    task automatic wait_hs(input string tag, input bit is_miss);
        int  n;
        logic r;
        n = 0;
        forever begin
            r = is_miss ? miss_ready_o : beat_ready_o;
            @(posedge clk); #1;
            if (r) break;
            n++;
            if (n > 50) begin
                check({tag, "_timeout"}, 0, 1);
                break;
            end
        end
    endtask

    task automatic send_miss(input logic [8:0] idx, input logic [5:0] off);
        miss_valid_i  = 1'b1;
        miss_index_i  = idx;
        miss_offset_i = off;
        wait_hs("miss_hs", 1'b1);
        miss_valid_i  = 1'b0;
    endtask

    task automatic burst(input logic [7:0] base, input int n, input int last_at, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                beat_valid_i = 1'b0;
                repeat ($urandom_range(0, 1)) @(posedge clk);
                #0;
            end
            beat_valid_i = 1'b1;
            beat_data_i  = bv(base + 8'(k));
            beat_last_i  = (k == last_at);
            wait_hs("beat_hs", 1'b0);
        end
        beat_valid_i = 1'b0;
        beat_last_i  = 1'b0;
    endtask

    // Called right after the final beat handshake: line must already be valid.
    task automatic expect_line(input string tag, input logic [511:0] exp_line,
                               input logic [8:0] exp_idx, input logic exp_err);
        check({tag, "_valid"}, line_valid_o, 1);
        check({tag, "_data"}, line_data_o, exp_line);
        check({tag, "_index"}, line_index_o, exp_idx);
        check({tag, "_err"}, err_o, exp_err);
        line_ready_i = 1'b1;
        @(posedge clk); #1;
        line_ready_i = 1'b0;
        check({tag, "_valid_drop"}, line_valid_o, 0);
    endtask

    logic [511:0] l3;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_miss_ready", miss_ready_o, 1);
        check("rst_beat_ready", beat_ready_o, 0);
        check("rst_line_valid", line_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_line_data", line_data_o, 0);
        check("rst_line_index", line_index_o, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Aligned burst with line_ready held high in advance
        line_ready_i = 1'b1;
        send_miss(9'h012, 6'h00);
        check("t1_beat_ready", beat_ready_o, 1);
        check("t1_miss_ready", miss_ready_o, 0);
        burst(8'h10, 8, 7, 1'b0);
        check("t1_valid_lat", line_valid_o, 1);
        check("t1_data", line_data_o, ln(bv(8'h10), bv(8'h11), bv(8'h12), bv(8'h13),
                                          bv(8'h14), bv(8'h15), bv(8'h16), bv(8'h17)));
        @(posedge clk); #1;
        line_ready_i = 1'b0;
        check("t1_valid_one_cycle", line_valid_o, 0);
        check("t1_err", err_o, 0);

        // Wrapped burst, w0 = 5
        send_miss(9'h1A5, 6'h28);
        burst(8'hA0, 8, 7, 1'b0);
        expect_line("t2", ln(bv(8'hA3), bv(8'hA4), bv(8'hA5), bv(8'hA6),
                             bv(8'hA7), bv(8'hA0), bv(8'hA1), bv(8'hA2)), 9'h1A5, 1'b0);

        // Back-pressure on the line with the next miss and a beat pending
        l3 = ln(bv(8'hC6), bv(8'hC7), bv(8'hC0), bv(8'hC1), bv(8'hC2), bv(8'hC3), bv(8'hC4), bv(8'hC5));
        send_miss(9'h033, 6'h10);
        burst(8'hC0, 8, 7, 1'b0);
        miss_valid_i  = 1'b1;
        miss_index_i  = 9'h044;
        miss_offset_i = 6'h00;
        beat_valid_i  = 1'b1;
        beat_data_i   = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            check("t3_hold_valid", line_valid_o, 1);
            check("t3_hold_data", line_data_o, l3);
            check("t3_hold_miss_ready", miss_ready_o, 0);
            check("t3_hold_beat_ready", beat_ready_o, 0);
            @(posedge clk); #1;
        end
        check("t3_hold_index", line_index_o, 9'h033);
        beat_valid_i = 1'b0;
        line_ready_i = 1'b1;
        @(posedge clk); #1;
        line_ready_i = 1'b0;
        check("t3_bubble_valid", line_valid_o, 0);
        check("t3_bubble_miss_ready", miss_ready_o, 1);
        check("t3_bubble_beat_ready", beat_ready_o, 0);
        @(posedge clk); #1;
        miss_valid_i = 1'b0;
        check("t3_next_miss_taken", miss_ready_o, 0);
        check("t3_next_beat_ready", beat_ready_o, 1);
        burst(8'hE0, 8, 7, 1'b0);
        expect_line("t3b", ln(bv(8'hE0), bv(8'hE1), bv(8'hE2), bv(8'hE3),
                              bv(8'hE4), bv(8'hE5), bv(8'hE6), bv(8'hE7)), 9'h044, 1'b0);

        // Random beat gaps, w0 = 7
        send_miss(9'h0F0, 6'h38);
        burst(8'hB0, 8, 7, 1'b1);
        expect_line("t4", ln(bv(8'hB1), bv(8'hB2), bv(8'hB3), bv(8'hB4),
                             bv(8'hB5), bv(8'hB6), bv(8'hB7), bv(8'hB0)), 9'h0F0, 1'b0);

        // Early last on beat 3
        send_miss(9'h055, 6'h00);
        burst(8'h50, 4, 3, 1'b0);
        expect_line("t5a", ln(bv(8'h50), bv(8'h51), bv(8'h52), bv(8'h53),
                              64'h0, 64'h0, 64'h0, 64'h0), 9'h055, 1'b1);
        // Missing last after 8 beats; a ninth beat must stall
        send_miss(9'h066, 6'h00);
        burst(8'h60, 8, -1, 1'b0);
        expect_line("t5b", ln(bv(8'h60), bv(8'h61), bv(8'h62), bv(8'h63),
                              bv(8'h64), bv(8'h65), bv(8'h66), bv(8'h67)), 9'h066, 1'b1);
        beat_valid_i = 1'b1;
        beat_data_i  = bv(8'h68);
        repeat (2) begin
            check("t5b_extra_beat_stall", beat_ready_o, 0);
            @(posedge clk); #1;
        end
        beat_valid_i = 1'b0;
        check("t5_err_sticky", err_o, 1);

        // Reset mid-burst discards the partial line
        send_miss(9'h077, 6'h00);
        burst(8'h70, 4, -1, 1'b0);
        rst = 1'b1;
        #2;
        check("t6_rst_err", err_o, 0);
        check("t6_rst_beat_ready", beat_ready_o, 0);
        check("t6_rst_miss_ready", miss_ready_o, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_rst_line_data", line_data_o, 0);
        repeat (3) begin
            check("t6_no_stale_line", line_valid_o, 0);
            @(posedge clk); #1;
        end
        send_miss(9'h099, 6'h08);
        burst(8'h80, 8, 7, 1'b0);
        expect_line("t6", ln(bv(8'h87), bv(8'h80), bv(8'h81), bv(8'h82),
                             bv(8'h83), bv(8'h84), bv(8'h85), bv(8'h86)), 9'h099, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
